cordic_rotation_engine: RTL
===========================

# cordic_rotation_engine

Iterative circular-mode CORDIC engine for the neuron activation datapath. It reads the 8-entry, 8-bit angle-constant ROM: it drives the 3-bit ROM address and consumes the 8-bit angle one iteration per cycle. It performs 8 micro-rotations on a signed (x, y, z) triple under a start/busy/done handshake. It sits between the neuron accumulator and the activation output stage.

## Interface

Parameters:
- W, 12, signed width of x/y data path and outputs
- ZW, 10, signed width of angle accumulator z (≥ 8 + 2)
- N_ITER, 8, iteration count; equals ROM depth; fixed, not to be overridden

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- x_in  input  W  signed initial x
- y_in  input  W  signed initial y
- z_in  input  ZW  signed target angle, ROM angle units
- rom_addr  output  3  ROM address = current iteration index
- rom_data  input  8  unsigned angle constant; combinational, valid the same cycle as rom_addr
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse when results are valid
- x_out  output  W  signed result x, held until next done
- y_out  output  W  signed result y
- z_out  output  ZW  signed residual angle

## Operation

- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 loads x_in/y_in/z_in into working registers xr/yr/zr and clears idx to 0.
  - Next state is RUN.
  - start=0 keeps the engine in IDLE.
- RUN: each cycle performs iteration i = idx.
  - d = +1 if zr ≥ 0 (zero counts as positive), else −1.
  - xr' = xr − d·(yr >>> i)
  - yr' = yr + d·(xr >>> i), computed from old xr/yr, not updated values
  - zr' = zr − d·zext(rom_data)
  - idx increments each cycle.
  - When idx=7, the update is applied and the next state is DONE.
- DONE: x_out/y_out/z_out are loaded from xr/yr/zr on entry; done=1 for this single cycle; next state is IDLE.
- Arithmetic:
  - Shifts are arithmetic (sign-preserving, floor toward −∞).
  - All adds are two's complement wrap in W/ZW bits, with no saturation.
  - Callers keep |x_in|, |y_in| < 2^(W−2), which absorbs the ≈1.65 CORDIC gain.
  - Gain is not compensated in this block.
- rom_addr = idx in RUN; 0 in IDLE and DONE.
- start while busy or in DONE is ignored and not queued.
- Reset mid-operation aborts the computation. Partial results are discarded and never appear on the outputs.

## Timing

- Reset values: state=IDLE, idx=0, rom_addr=0, busy=0, done=0, x_out=0, y_out=0, z_out=0, xr/yr/zr=0.
- Start sampled at edge E0 → busy=1 for the 8 cycles following E0 (edges E1..E8 apply iterations 0..7).
- done=1 and outputs valid in the cycle after E8. Start-to-done latency is 9 cycles.
- busy and done are never high together.
- Back-to-back: start high during the done cycle is ignored. The earliest accepted restart is the following cycle (IDLE), giving a throughput of 1 result per 10 cycles.
- Outputs change only at the DONE-entry edge or on reset.

## Structure

- Package cordic_pkg holds:
  - N_ITER=8, ADDR_W=3, ANGLE_W=8
  - state enum {IDLE, RUN, DONE}
- Sub-module cordic_micro_rotation:
  - Purely combinational single-iteration datapath.
  - Inputs: xr, yr, zr, shift i, angle.
  - Outputs: next xr, yr, zr.
  - The engine holds the FSM, counter and registers.
- The bench instantiates the existing angle ROM and connects rom_addr/rom_data to it.
  - ROM contents by address 0..7: 70, 32, 16, 8, 4, 2, 1, 1.

## Test plan

- Reset mid-RUN (assert rst after 4 iterations) → all outputs 0, busy=0; a fresh start then yields a correct result.
- x=100, y=0, z=0:
  - iteration trace: (100,100,−70), (150,50,−38), (162,13,−22), (163,−7,−14), (162,−17,−10), (161,−22,−8), (160,−24,−7)
  - final result: x_out=159, y_out=−25, z_out=−6
- x=100, y=0, z=0, timing:
  - done exactly 9 cycles after the start edge
  - busy high for exactly 8 cycles
  - rom_addr sequence 0..7 during RUN
- start held high continuously for 40 cycles → 4 done pulses, spaced 10 cycles apart; no start accepted during busy/done.
- x=0, y=0, z=−200:
  - d=−1 every iteration
  - z_out = −200 + 134 = −66
  - x_out=0, y_out=0
- x=1023, y=−1024, z=0 → outputs match a bit-exact reference model including wraparound; no X/Z on any output.

Source files
------------

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared constants and state encoding for the CORDIC rotation engine
//
// Purpose: iteration count, ROM address/data widths and the engine state enum.
package cordic_pkg;

   localparam int N_ITER  = 8;
   localparam int ADDR_W  = 3;
   localparam int ANGLE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/cordic_micro_rotation.sv
// rtl/cordic_micro_rotation.sv - combinational single-iteration circular CORDIC datapath
//
// Purpose: one micro-rotation of (xr, yr, zr) by the ROM angle for shift i.
// Ports:
//   xr, yr   in   W    signed working x/y
//   zr       in   ZW   signed residual angle
//   shift    in   3    iteration index i (arithmetic shift amount)
//   angle    in   8    unsigned angle constant for iteration i
//   xr_nxt   out  W    xr - d*(yr >>> i)
//   yr_nxt   out  W    yr + d*(xr >>> i)
//   zr_nxt   out  ZW   zr - d*zext(angle)
module cordic_micro_rotation
   import cordic_pkg::*;
#(
   parameter int W  = 12,
   parameter int ZW = 10
) (
   input  logic signed [W-1:0]       xr,
   input  logic signed [W-1:0]       yr,
   input  logic signed [ZW-1:0]      zr,
   input  logic        [ADDR_W-1:0]  shift,
   input  logic        [ANGLE_W-1:0] angle,
   output logic signed [W-1:0]       xr_nxt,
   output logic signed [W-1:0]       yr_nxt,
   output logic signed [ZW-1:0]      zr_nxt
);

   logic signed [W-1:0]  xs;
   logic signed [W-1:0]  ys;
   logic signed [ZW-1:0] angle_z;
   logic                 d_pos;

   // Both shifts use the old xr/yr so the rotation is a true simultaneous update.
   assign xs      = xr >>> shift;
   assign ys      = yr >>> shift;
   assign angle_z = $signed({{(ZW-ANGLE_W){1'b0}}, angle});

   // Zero residual rotates in the positive direction.
   assign d_pos   = ~zr[ZW-1];

   // Two's complement wrap in W/ZW bits; no saturation by design.
   assign xr_nxt  = d_pos ? (xr - ys)      : (xr + ys);
   assign yr_nxt  = d_pos ? (yr + xs)      : (yr - xs);
   assign zr_nxt  = d_pos ? (zr - angle_z) : (zr + angle_z);

endmodule

// File: rtl/cordic_rotation_engine.sv
// rtl/cordic_rotation_engine.sv - iterative 8-step circular-mode CORDIC with start/busy/done handshake
//
// Purpose: loads (x, y, z) on start, runs one micro-rotation per cycle using the
// external angle ROM, and presents the result with a one-cycle done pulse.
// Ports:
//   clk, rst   in   1    clock; asynchronous active-high reset
//   start      in   1    request, sampled only in IDLE
//   x_in/y_in  in   W    signed initial vector
//   z_in       in   ZW   signed target angle in ROM angle units
//   rom_addr   out  3    current iteration index during RUN, else 0
//   rom_data   in   8    unsigned angle constant for rom_addr (same cycle)
//   busy       out  1    high while iterating
//   done       out  1    one-cycle pulse, results valid
//   x_out/y_out out W    signed result, held until next done
//   z_out      out  ZW   signed residual angle
module cordic_rotation_engine #(
   parameter int W      = 12,
   parameter int ZW     = 10,
   parameter int N_ITER = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic signed [W-1:0]                  x_in,
   input  logic signed [W-1:0]                  y_in,
   input  logic signed [ZW-1:0]                 z_in,
   output logic        [cordic_pkg::ADDR_W-1:0] rom_addr,
   input  logic        [cordic_pkg::ANGLE_W-1:0] rom_data,
   output logic                                 busy,
   output logic                                 done,
   output logic signed [W-1:0]                  x_out,
   output logic signed [W-1:0]                  y_out,
   output logic signed [ZW-1:0]                 z_out
);

   import cordic_pkg::*;

   state_t               state;
   state_t               state_nxt;
   logic [ADDR_W-1:0]    idx;
   logic signed [W-1:0]  xr;
   logic signed [W-1:0]  yr;
   logic signed [ZW-1:0] zr;
   logic signed [W-1:0]  xr_nxt;
   logic signed [W-1:0]  yr_nxt;
   logic signed [ZW-1:0] zr_nxt;
   logic                 last_iter;

   assign last_iter = (idx == ADDR_W'(N_ITER - 1));

   cordic_micro_rotation #(
      .W  (W),
      .ZW (ZW)
   ) u_micro (
      .xr     (xr),
      .yr     (yr),
      .zr     (zr),
      .shift  (idx),
      .angle  (rom_data),
      .xr_nxt (xr_nxt),
      .yr_nxt (yr_nxt),
      .zr_nxt (zr_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         xr    <= '0;
         yr    <= '0;
         zr    <= '0;
         x_out <= '0;
         y_out <= '0;
         z_out <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  xr  <= x_in;
                  yr  <= y_in;
                  zr  <= z_in;
                  idx <= '0;
               end
            end
            RUN: begin
               xr  <= xr_nxt;
               yr  <= yr_nxt;
               zr  <= zr_nxt;
               idx <= idx + ADDR_W'(1);
               // Outputs take the final iteration's result on the DONE-entry edge,
               // so they never show partial values.
               if (last_iter) begin
                  x_out <= xr_nxt;
                  y_out <= yr_nxt;
                  z_out <= zr_nxt;
               end
            end
            DONE: begin
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      rom_addr  = '0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy     = 1'b1;
            rom_addr = idx;
            if (last_iter) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            // start is deliberately not looked at here: no queued restart.
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule
